// File: rtl/operand_issue_stage_pkg.sv
// Shared widths, ALU command codes, opcode map and instruction field positions
// for the operand issue stage and its register file.
package operand_issue_stage_pkg;

    localparam int WORD_LEN     = 16;
    localparam int REG_COUNT    = 8;
    localparam int REG_ADDR_LEN = 3;
    localparam int EXE_CMD_LEN  = 4;
    localparam int IMM_LEN      = 6;

    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'd0;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'd1;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'd2;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = 4'd3;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR = 4'd4;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLL = 4'd5;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRL = 4'd6;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_ADDI = 4'h8,
        OP_SLLI = 4'h9,
        OP_SRLI = 4'hA,
        OP_NOP  = 4'hF
    } opcode_t;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;

    function automatic logic [WORD_LEN-1:0] sext_imm(input logic [IMM_LEN-1:0] imm);
        return {{(WORD_LEN-IMM_LEN){imm[IMM_LEN-1]}}, imm};
    endfunction

    function automatic logic [WORD_LEN-1:0] zext_imm(input logic [IMM_LEN-1:0] imm);
        return {{(WORD_LEN-IMM_LEN){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two async read ports, one sync write port, r0 reads as 0.
// Writes to r0 are dropped; synchronous reset clears every entry.
module reg_file_8x16
    import operand_issue_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] ra1,
    output logic [WORD_LEN-1:0]     rd1,
    input  logic [REG_ADDR_LEN-1:0] ra2,
    output logic [WORD_LEN-1:0]     rd2,
    input  logic                    we,
    input  logic [REG_ADDR_LEN-1:0] wa,
    input  logic [WORD_LEN-1:0]     wd
);

    logic [WORD_LEN-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/operand_issue_stage.sv
// Decode + operand fetch with EX->ID and writeback forwarding, registering ALU inputs.
// Latency 1 cycle; stall holds the EXE register, flush (dominant) inserts a bubble.
module operand_issue_stage
    import operand_issue_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [15:0]             instr,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [WORD_LEN-1:0]     alu_result,
    input  logic                    wb_en,
    input  logic [REG_ADDR_LEN-1:0] wb_rd,
    input  logic [WORD_LEN-1:0]     wb_data,
    output logic [WORD_LEN-1:0]     ALUa,
    output logic [WORD_LEN-1:0]     ALUb,
    output logic [EXE_CMD_LEN-1:0]  EXE_CMD,
    output logic                    exe_valid,
    output logic [REG_ADDR_LEN-1:0] exe_rd,
    output logic                    exe_wen,
    output logic                    illegal
);

    opcode_t                 opc;
    logic [REG_ADDR_LEN-1:0] rd, rs1, rs2;
    logic [IMM_LEN-1:0]      imm6;
    logic [WORD_LEN-1:0]     rf_rd1, rf_rd2, opa, opb, b_imm;
    logic [EXE_CMD_LEN-1:0]  cmd;
    logic                    legal, use_imm, is_nop;

    assign opc  = opcode_t'(instr[OPC_LSB +: 4]);
    assign rd   = instr[RD_LSB  +: REG_ADDR_LEN];
    assign rs1  = instr[RS1_LSB +: REG_ADDR_LEN];
    assign rs2  = instr[RS2_LSB +: REG_ADDR_LEN];
    assign imm6 = instr[IMM_LSB +: IMM_LEN];

    reg_file_8x16 u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .rd1 (rf_rd1),
        .ra2 (rs2),
        .rd2 (rf_rd2),
        .we  (wb_en),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

    // EX forward beats the same-cycle writeback because it is the younger value.
    function automatic logic [WORD_LEN-1:0] pick_operand(
        input logic [REG_ADDR_LEN-1:0] rs,
        input logic [WORD_LEN-1:0]     rf_val,
        input logic                    ex_hit_en,
        input logic [REG_ADDR_LEN-1:0] ex_rd,
        input logic [WORD_LEN-1:0]     ex_val,
        input logic                    w_en,
        input logic [REG_ADDR_LEN-1:0] w_rd,
        input logic [WORD_LEN-1:0]     w_val
    );
        if (rs == '0)                    return '0;
        else if (ex_hit_en && ex_rd == rs) return ex_val;
        else if (w_en && w_rd == rs)     return w_val;
        else                             return rf_val;
    endfunction

    assign opa = pick_operand(rs1, rf_rd1, exe_wen && !stall, exe_rd, alu_result,
                              wb_en, wb_rd, wb_data);
    assign opb = pick_operand(rs2, rf_rd2, exe_wen && !stall, exe_rd, alu_result,
                              wb_en, wb_rd, wb_data);

    always_comb begin
        legal   = 1'b1;
        use_imm = 1'b0;
        is_nop  = 1'b0;
        cmd     = EXE_ADD;
        b_imm   = '0;
        case (opc)
            OP_ADD:  cmd = EXE_ADD;
            OP_SUB:  cmd = EXE_SUB;
            OP_AND:  cmd = EXE_AND;
            OP_OR:   cmd = EXE_OR;
            OP_XOR:  cmd = EXE_XOR;
            OP_SLL:  cmd = EXE_SLL;
            OP_SRL:  cmd = EXE_SRL;
            OP_ADDI: begin cmd = EXE_ADD; use_imm = 1'b1; b_imm = sext_imm(imm6); end
            OP_SLLI: begin cmd = EXE_SLL; use_imm = 1'b1; b_imm = zext_imm(imm6); end
            OP_SRLI: begin cmd = EXE_SRL; use_imm = 1'b1; b_imm = zext_imm(imm6); end
            OP_NOP:  is_nop = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALUa      <= '0;
            ALUb      <= '0;
            EXE_CMD   <= EXE_ADD;
            exe_valid <= 1'b0;
            exe_rd    <= '0;
            exe_wen   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            illegal <= instr_valid && !stall && !flush && !legal;
            if (flush || (!stall && !(instr_valid && legal))) begin
                ALUa      <= '0;
                ALUb      <= '0;
                EXE_CMD   <= EXE_ADD;
                exe_valid <= 1'b0;
                exe_rd    <= '0;
                exe_wen   <= 1'b0;
            end else if (!stall) begin
                ALUa      <= is_nop ? '0 : opa;
                ALUb      <= is_nop ? '0 : (use_imm ? b_imm : opb);
                EXE_CMD   <= cmd;
                exe_valid <= 1'b1;
                exe_rd    <= is_nop ? '0 : rd;
                exe_wen   <= !is_nop && rd != '0;
            end
        end
    end

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the ALU in the 16-bit three-stage pipeline.
- Decodes the fetched instruction and reads the 8x16 register file.
- Resolves data hazards by forwarding.
- Registers ALUa, ALUb and EXE_CMD into the EXE pipeline register that drives the ALU.
- Accepts the writeback port from stage 3 into its register file.

Parameters:
- WORD_LEN, 16, datapath width; matches the ALU operand width.
- REG_COUNT, 8, architectural registers; r0 reads as 0.
- REG_ADDR_LEN, 3, log2(REG_COUNT).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  the instr field holds a real instruction this cycle.
- instr  in  16  instruction word: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
- stall  in  1  hold the EXE register; the upstream block holds instr.
- flush  in  1  replace the EXE register contents with a bubble.
- alu_result  in  WORD_LEN  combinational ALU output for the instruction currently in EXE.
- wb_en  in  1  writeback enable from stage 3.
- wb_rd  in  REG_ADDR_LEN  writeback destination.
- wb_data  in  WORD_LEN  writeback value.
- ALUa  out  WORD_LEN  registered operand A.
- ALUb  out  WORD_LEN  registered operand B.
- EXE_CMD  out  EXE_CMD_LEN  registered ALU command.
- exe_valid  out  1  the EXE register holds a real instruction.
- exe_rd  out  REG_ADDR_LEN  destination of the EXE instruction.
- exe_wen  out  1  the EXE instruction writes rd (exe_valid && rd != 0).
- illegal  out  1  one-cycle pulse: an undefined opcode was dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ALUa=0, ALUb=0, EXE_CMD=EXE_ADD, exe_valid=0, exe_rd=0, exe_wen=0, illegal=0, all registers cleared to 0. Reset mid-operation discards the in-flight instruction; a wb_en in the same cycle is ignored.
- Opcode map (fixed):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL: register-register; ALUb = rs2 value.
  - 8 ADDI: EXE_ADD with ALUb = sign-extended imm6.
  - 9 SLLI: EXE_SLL with ALUb = zero-extended imm6.
  - A SRLI: EXE_SRL with ALUb = zero-extended imm6.
  - F NOP: valid, exe_wen=0.
  - All other opcodes are illegal.
- Operand source priority per source (rs1, and rs2 for register-register forms):
  1. rs==0 -> 0.
  2. exe_wen && exe_rd==rs && !stall -> alu_result (EX->ID forward).
  3. wb_en && wb_rd==rs -> wb_data (same-cycle write bypass).
  4. Register file.
- Register file write: on clk when wb_en && wb_rd!=0, regardless of stall or flush. Writes to r0 are dropped.
- Latency: an instruction presented in cycle N appears on the ALU inputs in cycle N+1. Throughput is 1 per cycle when no stall.
- EXE register update, evaluated each cycle (after rst):
  - flush -> bubble: exe_valid=0, exe_wen=0, EXE_CMD=EXE_ADD, ALUa=ALUb=0. flush wins over stall.
  - else stall -> all EXE outputs hold their values.
  - else instr_valid && legal -> load the decoded fields.
  - else -> bubble.
- illegal is asserted for exactly one cycle after an illegal opcode is accepted (instr_valid && !stall && !flush). The instruction becomes a bubble.
- ADDI sign extension: imm6 0x3F -> 0xFFFF, 0x20 -> 0xFFE0.
- Shift immediates above 15 are passed unchanged; the ALU defines the result.

Decomposition:
- Shared package: WORD_LEN, EXE_CMD_LEN, EXE_* command codes (existing), the opcode constants, REG_ADDR_LEN, instruction field bit positions.
- One sub-module: reg_file_8x16 (two async read ports, one sync write port, r0 hardwired to 0, synchronous reset clear).
- Decode, forwarding and the EXE register stay in operand_issue_stage.

Test Plan:
- Reset then wb r1=0x0005, r2=0x0003; issue ADD r3,r1,r2 -> next cycle ALUa=0x0005, ALUb=0x0003, EXE_CMD=EXE_ADD, exe_rd=3, exe_wen=1.
- Back-to-back ADD r3,r1,r2 then SUB r4,r3,r1 with alu_result=0x0008 -> SUB issues with ALUa=0x0008 (forwarded), ALUb=0x0005.
- ADDI r5,r0,imm6=0x3F -> ALUa=0x0000, ALUb=0xFFFF. Then wb_en with rd=0, data=0x1234, followed by a read of r0 -> operand is 0x0000.
- Same cycle: wb r2=0xAAAA and issue XOR r6,r2,r2 -> ALUa=ALUb=0xAAAA.
- Hold stall for 3 cycles with a pending OR -> outputs stable, and a wb to r1 still lands. Assert stall+flush together -> exe_valid=0 next cycle.
- Opcode 0xB with instr_valid -> illegal=1 for one cycle, exe_valid=0. Assert rst mid-stream -> all outputs return to their reset values next cycle.
